ua_pipelined: RTL and testbench
===============================

Name: ua_pipelined

Overview:
- Parametrised, pipelined successor to the Tomasulo integer arithmetic unit.
- Accepts an issued operation from a reservation station together with its RS tag, computes it over LAT register stages, and presents the result and tag for broadcast on the common data bus (CDB).
- Adds a valid/ready issue handshake, CDB-grant back-pressure, a flush for mispeculation, and a signed set-less-than op.

Parameters:
- W, 16, operand/result width in bits.
- TAGW, 3, reservation-station tag width.
- LAT, 2, pipeline depth in register stages (legal 1..4).

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  synchronous reset, active low.
- Valido  in  1  issue request; operands/op/Tag valid.
- Pronto  out  1  unit can accept an issue this cycle.
- Dado1  in  W  operand 1 (base for address ops).
- Dado2  in  W  operand 2 (offset for address ops).
- op  in  3  operation code.
- Tag  in  TAGW  RS tag of issuing entry.
- Limpa  in  1  flush all in-flight ops.
- Concedido  in  1  CDB grant for the current output.
- ResValido  out  1  result pending on CDB.
- Resultado  out  W  result.
- ResTag  out  TAGW  tag of result.

Behaviour:
- Reset (Resetn=0 at a rising edge):
  - All stage valid bits are cleared.
  - ResValido=0, Resultado=0, ResTag=0, Pronto=1 on the next cycle.
  - Reset takes priority over every other input.
- Op decode (computed in stage 1), all arithmetic modulo 2^W:
  - 001: Dado1+Dado2.
  - 010: Dado1-Dado2.
  - 011: Dado1+Dado2 (load address).
  - 100: Dado1+Dado2 (store address).
  - 101: signed compare; result 1 if Dado1<Dado2 as two's complement, else 0.
  - Any other code (000, 110, 111): result 0; the op still flows and is broadcast.
- Pipeline:
  - LAT stages, each holding {valid, result, tag}.
  - Stage LAT drives ResValido/Resultado/ResTag directly.
- Stall:
  - stall = ResValido & ~Concedido.
  - While stall, all stages hold; this is a global stall with no bubble collapsing.
  - Pronto = ~stall, combinational from registered state and Concedido.
- Handshake:
  - An issue is accepted at an edge where Valido & Pronto; it enters stage 1.
  - Valido with Pronto=0 is ignored; the RS must hold its request.
- Latency:
  - An op accepted at edge n is visible on the outputs right after edge n+LAT-1, provided no stall.
  - With Concedido held at 1, throughput is one op per cycle.
- Retire: while ResValido=1 and Concedido=1, the next edge shifts the pipeline. ResValido drops unless a new op arrives behind.
- Concedido while ResValido=0: ignored.
- Limpa:
  - At an edge with Limpa=1 and Resetn=1, all valid bits are cleared and ResValido=0 on the next cycle.
  - An issue presented in the same cycle is discarded (flush wins).
  - Resultado/ResTag hold their last values; they are don't-care while ResValido=0.
- Flush during stall: stall is released and Pronto=1 on the next cycle.
- Reset mid-operation: all in-flight ops are lost; no partial broadcast.
- Simultaneous retire and issue in the same cycle: both happen, with no bubble.

Optional Feature:
- Macro: UA_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port Transbordo, 1 bit, carried through the pipeline alongside the result.
  - Set on signed overflow of 001 (operands same sign, result sign differs) and 010 (operands differ in sign, result sign differs from Dado1).
  - 0 for all other ops.
  - Reset value 0; held during stall.
- Undefined: the port is absent and no overflow logic is generated.

Test Plan:
- LAT=2, W=16, Concedido=1; issue op=001, Dado1=0x0003, Dado2=0x0004, Tag=5 at edge 0 -> ResValido=1, Resultado=0x0007, ResTag=5 after edge 1; ResValido=0 after edge 2.
- Wrap and compare: op=001, Dado1=0xFFFF, Dado2=0x0002 -> Resultado=0x0001. Then op=101, Dado1=0x8000, Dado2=0x0001 -> Resultado=0x0001. Then op=010, Dado1=0x0000, Dado2=0x0001 -> Resultado=0xFFFF.
- Back-pressure: Concedido=0, issue 3 back-to-back ops (tags 1,2,3) -> tag 1 is held on the outputs, Pronto=0 once the pipe is full, and the third op is retried. Then raise Concedido -> tags emerge 1,2,3 in order on consecutive cycles with no loss or duplication.
- Flush: with 2 ops in flight, assert Limpa for 1 cycle while Valido=1 -> ResValido stays 0 for both, and the concurrent issue never appears.
- Reset mid-stream: Resetn=0 for one edge with ops in flight and stalled -> next cycle ResValido=0, Resultado=0, ResTag=0, Pronto=1. Undefined op=111 issued afterwards -> Resultado=0, ResValido=1 with its tag.
- UA_OVERFLOW_FLAG_EN defined: op=001, 0x7FFF+0x0001 -> Resultado=0x8000, Transbordo=1. op=010, 0x8000-0x0001 -> Transbordo=1. op=011 with the same operands -> Transbordo=0.

Source files
------------

// File: rtl/ua_pipelined.sv
// Pipelined Tomasulo integer unit: issue handshake, CDB-grant stall, flush, signed SLT.
// Define UA_OVERFLOW_FLAG_EN to add the Transbordo signed-overflow output.
module ua_pipelined #(
   parameter int W    = 16,
   parameter int TAGW = 3,
   parameter int LAT  = 2
) (
   input  logic            Clock,
   input  logic            Resetn,
   input  logic            Valido,
   output logic            Pronto,
   input  logic [W-1:0]    Dado1,
   input  logic [W-1:0]    Dado2,
   input  logic [2:0]      op,
   input  logic [TAGW-1:0] Tag,
   input  logic            Limpa,
   input  logic            Concedido,
   output logic            ResValido,
   output logic [W-1:0]    Resultado,
   output logic [TAGW-1:0] ResTag
`ifdef UA_OVERFLOW_FLAG_EN
   ,
   output logic            Transbordo
`endif
);

   logic [LAT-1:0]  vld;
   logic [W-1:0]    res  [LAT];
   logic [TAGW-1:0] tags [LAT];
   logic            stall;
   logic [W-1:0]    sum;
   logic [W-1:0]    diff;
   logic [W-1:0]    s1res;

   // A result waiting on the bus without a grant freezes the whole pipe.
   assign stall  = vld[LAT-1] & ~Concedido;
   assign Pronto = ~stall;

   assign sum  = Dado1 + Dado2;
   assign diff = Dado1 - Dado2;

   always_comb begin
      s1res = '0;
      case (op)
         3'b001:  s1res = sum;
         3'b010:  s1res = diff;
         3'b011:  s1res = sum;
         3'b100:  s1res = sum;
         3'b101:  s1res = {{(W-1){1'b0}}, ($signed(Dado1) < $signed(Dado2))};
         default: s1res = '0;
      endcase
   end

`ifdef UA_OVERFLOW_FLAG_EN
   logic ovf [LAT];
   logic s1ovf;

   always_comb begin
      s1ovf = 1'b0;
      case (op)
         3'b001:  s1ovf = (Dado1[W-1] == Dado2[W-1]) && (sum[W-1] != Dado1[W-1]);
         3'b010:  s1ovf = (Dado1[W-1] != Dado2[W-1]) && (diff[W-1] != Dado1[W-1]);
         default: s1ovf = 1'b0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         for (int i = 0; i < LAT; i++) ovf[i] <= 1'b0;
      end else if (!Limpa && !stall) begin
         ovf[0] <= s1ovf;
         for (int i = 1; i < LAT; i++) ovf[i] <= ovf[i-1];
      end
   end

   assign Transbordo = ovf[LAT-1];
`endif

   // Flush only drops valid bits; result/tag payloads keep their last values.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         vld <= '0;
         for (int i = 0; i < LAT; i++) begin
            res[i]  <= '0;
            tags[i] <= '0;
         end
      end else if (Limpa) begin
         vld <= '0;
      end else if (!stall) begin
         vld[0]  <= Valido;
         res[0]  <= s1res;
         tags[0] <= Tag;
         for (int i = 1; i < LAT; i++) begin
            vld[i]  <= vld[i-1];
            res[i]  <= res[i-1];
            tags[i] <= tags[i-1];
         end
      end
   end

   assign ResValido = vld[LAT-1];
   assign Resultado = res[LAT-1];
   assign ResTag    = tags[LAT-1];

endmodule

// File: tb/tb_ua_pipelined.sv
// Scoreboard bench for ua_pipelined (LAT=2, W=16): directed vectors with hand-computed results.
module tb_ua_pipelined;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        Valido;
   logic        Pronto;
   logic [15:0] Dado1;
   logic [15:0] Dado2;
   logic [2:0]  op;
   logic [2:0]  Tag;
   logic        Limpa;
   logic        Concedido;
   logic        ResValido;
   logic [15:0] Resultado;
   logic [2:0]  ResTag;
`ifdef UA_OVERFLOW_FLAG_EN
   logic        Transbordo;
`endif

   typedef struct packed {
      logic [15:0] res;
      logic [2:0]  tag;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   ua_pipelined #(.W(16), .TAGW(3), .LAT(2)) dut (
      .Clock(Clock), .Resetn(Resetn), .Valido(Valido), .Pronto(Pronto),
      .Dado1(Dado1), .Dado2(Dado2), .op(op), .Tag(Tag), .Limpa(Limpa),
      .Concedido(Concedido), .ResValido(ResValido), .Resultado(Resultado),
      .ResTag(ResTag)
`ifdef UA_OVERFLOW_FLAG_EN
      , .Transbordo(Transbordo)
`endif
   );

   always #5 Clock = ~Clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Drive one issue and queue its expected result; inputs stay asserted on return.
   task automatic applyStimulus(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                input logic [2:0] t, input logic [15:0] r, input logic v);
      op = o; Dado1 = a; Dado2 = b; Tag = t; Valido = 1'b1;
      sb.push_back('{res: r, tag: t, ovf: v});
      @(posedge Clock); #1;
   endtask

   task automatic idle();
      Valido = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   // Monitor: every visible result must match the queue head; a granted one retires.
   always @(negedge Clock) begin
      if (Resetn && ResValido) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_result_tag", {29'd0, ResTag}, 32'hFFFF_FFFF);
         end else begin
            checkOutput("resultado", {16'd0, Resultado}, {16'd0, sb[0].res});
            checkOutput("restag", {29'd0, ResTag}, {29'd0, sb[0].tag});
`ifdef UA_OVERFLOW_FLAG_EN
            checkOutput("transbordo", {31'd0, Transbordo}, {31'd0, sb[0].ovf});
`endif
            if (Concedido) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Resetn = 1'b0; Valido = 1'b0; Dado1 = '0; Dado2 = '0; op = '0; Tag = '0;
      Limpa = 1'b0; Concedido = 1'b1;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      checkOutput("reset_resvalido", {31'd0, ResValido}, 32'd0);
      checkOutput("reset_resultado", {16'd0, Resultado}, 32'd0);
      checkOutput("reset_restag", {29'd0, ResTag}, 32'd0);
      checkOutput("reset_pronto", {31'd0, Pronto}, 32'd1);
      @(posedge Clock); #1;
      Resetn = 1'b1;

      // Basic latency: visible one edge after acceptance, gone after the next.
      applyStimulus(3'b001, 16'h0003, 16'h0004, 3'd5, 16'h0007, 1'b0);
      idle();
      @(negedge Clock);
      checkOutput("lat_early", {31'd0, ResValido}, 32'd0);
      @(posedge Clock); #1;
      @(negedge Clock);
      checkOutput("lat_on_time", {31'd0, ResValido}, 32'd1);
      @(posedge Clock); #1;
      @(negedge Clock);
      checkOutput("lat_retired", {31'd0, ResValido}, 32'd0);
      @(posedge Clock); #1;

      // Wrap, signed compare, subtract underflow back to back.
      applyStimulus(3'b001, 16'hFFFF, 16'h0002, 3'd1, 16'h0001, 1'b0);
      applyStimulus(3'b101, 16'h8000, 16'h0001, 3'd2, 16'h0001, 1'b0);
      applyStimulus(3'b010, 16'h0000, 16'h0001, 3'd3, 16'hFFFF, 1'b0);
      idle();
      waitCycles(4);
      checkOutput("wrap_drained", sb.size(), 32'd0);

      // Back-pressure: third op is retried until the grant returns.
      Concedido = 1'b0;
      applyStimulus(3'b001, 16'h000A, 16'h0001, 3'd1, 16'h000B, 1'b0);
      applyStimulus(3'b010, 16'h0014, 16'h0005, 3'd2, 16'h000F, 1'b0);
      applyStimulus(3'b101, 16'h0005, 16'hFFFF, 3'd3, 16'h0000, 1'b0);
      @(negedge Clock);
      checkOutput("bp_pronto_full", {31'd0, Pronto}, 32'd0);
      checkOutput("bp_held_valid", {31'd0, ResValido}, 32'd1);
      waitCycles(2);
      Concedido = 1'b1;
      @(posedge Clock); #1;
      idle();
      waitCycles(3);
      checkOutput("bp_drained", sb.size(), 32'd0);

      // Flush while stalled with two ops in flight and a concurrent issue.
      Concedido = 1'b0;
      applyStimulus(3'b001, 16'h0001, 16'h0001, 3'd4, 16'h0002, 1'b0);
      applyStimulus(3'b010, 16'h0009, 16'h0002, 3'd5, 16'h0007, 1'b0);
      idle();
      op = 3'b001; Dado1 = 16'h0100; Dado2 = 16'h0100; Tag = 3'd7; Valido = 1'b1;
      Limpa = 1'b1;
      @(posedge Clock); #1;
      sb.delete();
      Limpa = 1'b0; Valido = 1'b0;
      @(negedge Clock);
      checkOutput("flush_resvalido", {31'd0, ResValido}, 32'd0);
      checkOutput("flush_pronto", {31'd0, Pronto}, 32'd1);
      Concedido = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         checkOutput("flush_quiet", {31'd0, ResValido}, 32'd0);
      end
      @(posedge Clock); #1;

      // Reset with stalled ops in flight, then an undefined op.
      Concedido = 1'b0;
      applyStimulus(3'b011, 16'h1000, 16'h0010, 3'd2, 16'h1010, 1'b0);
      applyStimulus(3'b100, 16'h2000, 16'h0020, 3'd3, 16'h2020, 1'b0);
      idle();
      waitCycles(1);
      Resetn = 1'b0;
      @(posedge Clock); #1;
      Resetn = 1'b1;
      sb.delete();
      @(negedge Clock);
      checkOutput("rst_mid_resvalido", {31'd0, ResValido}, 32'd0);
      checkOutput("rst_mid_resultado", {16'd0, Resultado}, 32'd0);
      checkOutput("rst_mid_restag", {29'd0, ResTag}, 32'd0);
      checkOutput("rst_mid_pronto", {31'd0, Pronto}, 32'd1);
      @(posedge Clock); #1;
      Concedido = 1'b1;
      applyStimulus(3'b111, 16'h1234, 16'h5678, 3'd6, 16'h0000, 1'b0);
      idle();
      waitCycles(3);

      // Signed-overflow vectors; results are checked in every build.
      applyStimulus(3'b001, 16'h7FFF, 16'h0001, 3'd1, 16'h8000, 1'b1);
      applyStimulus(3'b010, 16'h8000, 16'h0001, 3'd2, 16'h7FFF, 1'b1);
      applyStimulus(3'b011, 16'h8000, 16'h0001, 3'd3, 16'h8001, 1'b0);
      idle();

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge Clock);
      #1;
      checkOutput("final_drain", sb.size(), 32'd0);
      waitCycles(2);
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
